mem_arbiter: RTL and testbench

Two-port-to-one memory arbiter between the pipeline's instruction port (a, fetch) and data port (b, MEM stage) and a single shared physical memory (pmem). Registers the winning request, holds it stable on pmem until pmem_resp, then routes the response back to the owner. Tie-breaking is round-robin with data-first after reset. Sits between the datapath's mem_*_a/mem_*_b ports and the memory model or cache.

---
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port to one-memory arbiter: registers the winning request onto pmem,
// holds it until pmem_resp, then pulses the owner's response. Round-robin ties.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read_a,
    input  logic                  mem_write_a,
    input  logic [1:0]            mem_wmask_a,
    input  logic [ADDR_WIDTH-1:0] mem_address_a,
    input  logic [DATA_WIDTH-1:0] mem_wdata_a,
    output logic                  mem_resp_a,
    output logic [DATA_WIDTH-1:0] mem_rdata_a,
    input  logic                  mem_read_b,
    input  logic                  mem_write_b,
    input  logic [1:0]            mem_wmask_b,
    input  logic [ADDR_WIDTH-1:0] mem_address_b,
    input  logic [DATA_WIDTH-1:0] mem_wdata_b,
    output logic                  mem_resp_b,
    output logic [DATA_WIDTH-1:0] mem_rdata_b,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [1:0]            pmem_wmask,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [DATA_WIDTH-1:0] pmem_wdata,
    input  logic                  pmem_resp,
    input  logic [DATA_WIDTH-1:0] pmem_rdata,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  conflict_count
);

    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

    state_t                r_state;
    logic                  r_last_b;
    logic                  r_pmem_read;
    logic                  r_pmem_write;
    logic [1:0]            r_pmem_wmask;
    logic [ADDR_WIDTH-1:0] r_pmem_address;
    logic [DATA_WIDTH-1:0] r_pmem_wdata;
    logic [CNT_WIDTH-1:0]  r_conflict_count;

    logic w_req_a;
    logic w_req_b;
    logic w_pick_b;

    assign w_req_a  = mem_read_a | mem_write_a;
    assign w_req_b  = mem_read_b | mem_write_b;
    // On a tie the port that did not win last time goes first.
    assign w_pick_b = w_req_b & (~w_req_a | ~r_last_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_last_b         <= 1'b0;
            r_pmem_read      <= 1'b0;
            r_pmem_write     <= 1'b0;
            r_pmem_wmask     <= '0;
            r_pmem_address   <= '0;
            r_pmem_wdata     <= '0;
            r_conflict_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_a && w_req_b && (r_conflict_count != '1))
                        r_conflict_count <= r_conflict_count + CNT_WIDTH'(1);
                    if (w_pick_b) begin
                        r_state        <= GRANT_B;
                        r_last_b       <= 1'b1;
                        r_pmem_write   <= mem_write_b;
                        r_pmem_read    <= mem_read_b & ~mem_write_b;
                        r_pmem_wmask   <= mem_wmask_b;
                        r_pmem_address <= mem_address_b;
                        r_pmem_wdata   <= mem_wdata_b;
                    end else if (w_req_a) begin
                        r_state        <= GRANT_A;
                        r_last_b       <= 1'b0;
                        r_pmem_write   <= mem_write_a;
                        r_pmem_read    <= mem_read_a & ~mem_write_a;
                        r_pmem_wmask   <= mem_wmask_a;
                        r_pmem_address <= mem_address_a;
                        r_pmem_wdata   <= mem_wdata_a;
                    end
                end
                GRANT_A, GRANT_B: begin
                    if (pmem_resp) begin
                        r_state      <= IDLE;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A withdrawn (flushed) request still completes on pmem but gets no response.
    assign mem_resp_a     = pmem_resp & (r_state == GRANT_A) & w_req_a;
    assign mem_resp_b     = pmem_resp & (r_state == GRANT_B) & w_req_b;
    assign mem_rdata_a    = pmem_rdata;
    assign mem_rdata_b    = pmem_rdata;
    assign pmem_read      = r_pmem_read;
    assign pmem_write     = r_pmem_write;
    assign pmem_wmask     = r_pmem_wmask;
    assign pmem_address   = r_pmem_address;
    assign pmem_wdata     = r_pmem_wdata;
    assign busy           = (r_state != IDLE);
    assign conflict_count = r_conflict_count;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single grants, round-robin ties, write priority,
// flushed requests and asynchronous reset mid-transaction.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read_a = 0, mem_write_a = 0;
    logic [1:0]  mem_wmask_a = 0;
    logic [15:0] mem_address_a = 0, mem_wdata_a = 0;
    logic        mem_resp_a;
    logic [15:0] mem_rdata_a;
    logic        mem_read_b = 0, mem_write_b = 0;
    logic [1:0]  mem_wmask_b = 0;
    logic [15:0] mem_address_b = 0, mem_wdata_b = 0;
    logic        mem_resp_b;
    logic [15:0] mem_rdata_b;
    logic        pmem_read, pmem_write;
    logic [1:0]  pmem_wmask;
    logic [15:0] pmem_address, pmem_wdata;
    logic        pmem_resp = 0;
    logic [15:0] pmem_rdata = 0;
    logic        busy;
    logic [15:0] conflict_count;

    int checks = 0;
    int failures = 0;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read_a(mem_read_a), .mem_write_a(mem_write_a), .mem_wmask_a(mem_wmask_a),
        .mem_address_a(mem_address_a), .mem_wdata_a(mem_wdata_a),
        .mem_resp_a(mem_resp_a), .mem_rdata_a(mem_rdata_a),
        .mem_read_b(mem_read_b), .mem_write_b(mem_write_b), .mem_wmask_b(mem_wmask_b),
        .mem_address_b(mem_address_b), .mem_wdata_b(mem_wdata_b),
        .mem_resp_b(mem_resp_b), .mem_rdata_b(mem_rdata_b),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
        .busy(busy), .conflict_count(conflict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-22s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_busy", busy, 0);
        check("rst_pmem_read", pmem_read, 0);
        check("rst_pmem_write", pmem_write, 0);
        check("rst_pmem_addr", pmem_address, 0);
        check("rst_conflict", conflict_count, 0);
        rst_n = 1'b1;
        tick();

        // Port a read only
        mem_read_a = 1; mem_address_a = 16'h0040;
        check("t1_idle_pmem_read", pmem_read, 0);
        tick();
        check("t1_pmem_read", pmem_read, 1);
        check("t1_pmem_addr", pmem_address, 16'h0040);
        check("t1_busy", busy, 1);
        tick();
        tick();
        pmem_resp = 1; pmem_rdata = 16'h1234;
        #1;
        check("t1_resp_a", mem_resp_a, 1);
        check("t1_rdata_a", mem_rdata_a, 16'h1234);
        check("t1_resp_b", mem_resp_b, 0);
        tick();
        pmem_resp = 0; mem_read_a = 0;
        check("t1_busy_after", busy, 0);
        check("t1_pmem_read_after", pmem_read, 0);
        tick();
        check("t1_idle_busy", busy, 0);

        // Tie from reset: b first, then a
        do_reset();
        mem_read_a = 1; mem_address_a = 16'h0000;
        mem_write_b = 1; mem_address_b = 16'h0100; mem_wdata_b = 16'hBEEF; mem_wmask_b = 2'b01;
        tick();
        check("t2_pmem_write", pmem_write, 1);
        check("t2_pmem_read", pmem_read, 0);
        check("t2_pmem_wmask", pmem_wmask, 2'b01);
        check("t2_pmem_wdata", pmem_wdata, 16'hBEEF);
        check("t2_pmem_addr", pmem_address, 16'h0100);
        check("t2_conflict", conflict_count, 1);
        pmem_resp = 1;
        #1;
        check("t2_resp_b", mem_resp_b, 1);
        check("t2_resp_a_none", mem_resp_a, 0);
        tick();
        pmem_resp = 0; mem_write_b = 0;
        check("t2_idle_busy", busy, 0);
        check("t2_idle_strobe", pmem_write, 0);
        tick();
        check("t2_a_pmem_read", pmem_read, 1);
        check("t2_a_addr", pmem_address, 16'h0000);
        check("t2_conflict_hold", conflict_count, 1);
        pmem_resp = 1;
        #1;
        check("t2_resp_a", mem_resp_a, 1);
        tick();
        pmem_resp = 0; mem_read_a = 0;

        // Four held tie transactions: b,a,b,a
        do_reset();
        mem_read_a = 1; mem_address_a = 16'h0A00;
        mem_read_b = 1; mem_address_b = 16'h0B00;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_grant_addr", pmem_address, (i % 2 == 0) ? 16'h0B00 : 16'h0A00);
            tick();
            pmem_resp = 1;
            #1;
            check("t3_resp_a", mem_resp_a, (i % 2 == 0) ? 0 : 1);
            check("t3_resp_b", mem_resp_b, (i % 2 == 0) ? 1 : 0);
            tick();
            pmem_resp = 0;
            check("t3_no_grant_in_resp", busy, 0);
        end
        check("t3_conflict", conflict_count, 4);
        mem_read_a = 0; mem_read_b = 0;
        tick();

        // b read+write together: write wins
        mem_read_b = 1; mem_write_b = 1; mem_address_b = 16'h0200;
        tick();
        check("t4_pmem_write", pmem_write, 1);
        check("t4_pmem_read", pmem_read, 0);
        check("t4_pmem_addr", pmem_address, 16'h0200);
        pmem_resp = 1;
        #1;
        check("t4_resp_b", mem_resp_b, 1);
        tick();
        pmem_resp = 0; mem_read_b = 0; mem_write_b = 0;
        tick();

        // Flush: a withdraws before pmem_resp
        mem_read_a = 1; mem_address_a = 16'h0010;
        tick();
        check("t5_pmem_read", pmem_read, 1);
        check("t5_pmem_addr", pmem_address, 16'h0010);
        mem_read_a = 0;
        tick();
        check("t5_pmem_read_held", pmem_read, 1);
        check("t5_busy_held", busy, 1);
        pmem_resp = 1;
        #1;
        check("t5_resp_a_dropped", mem_resp_a, 0);
        tick();
        pmem_resp = 0;
        check("t5_idle_busy", busy, 0);
        check("t5_pmem_read_clr", pmem_read, 0);

        // Asynchronous reset during GRANT_B
        check("t6_conflict_pre", conflict_count, 4);
        mem_write_b = 1; mem_address_b = 16'h0300; mem_wdata_b = 16'h5555;
        tick();
        check("t6_pmem_write", pmem_write, 1);
        #2;
        rst_n = 0;
        #1;
        check("t6_rst_pmem_write", pmem_write, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_conflict", conflict_count, 0);
        check("t6_rst_addr", pmem_address, 0);
        mem_write_b = 0;
        tick();
        rst_n = 1;
        #1;
        pmem_resp = 1;
        #1;
        check("t6_stray_resp_a", mem_resp_a, 0);
        check("t6_stray_resp_b", mem_resp_b, 0);
        tick();
        pmem_resp = 0;
        check("t6_stray_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
